// File: rtl/led_spin_sequencer.sv
// LED spin sequencer: steps a position around 8 LEDs at a programmable rate
// and decodes it into dot, bar, fill or bounce patterns.
module led_spin_sequencer #(
  parameter int unsigned BASE_DIV = 4,
  parameter int unsigned DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [2:0] speed,
  input  logic [1:0] mode,
  output logic [7:0] led,
  output logic       step,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MODE_DOT    = 2'd0;
  localparam logic [1:0] MODE_BAR    = 2'd1;
  localparam logic [1:0] MODE_FILL   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  state_t           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic             bounce_q, bounce_d;
  logic             step_q, step_d;
  logic [1:0]       mode_prev_q, mode_prev_d;

  logic [DIV_W-1:0] term_c;
  logic             flag_c;
  logic [2:0]       pos_adv_c;
  logic             flag_adv_c;

  // Terminal count follows speed live so a speed drop mid-period steps at once
  assign term_c = (DIV_W'(BASE_DIV) << speed) - DIV_W'(1);

  // Next position and bounce direction if a step were taken this cycle
  always_comb begin
    flag_c = bounce_q;
    if ((mode == MODE_BOUNCE) && (mode_prev_q != MODE_BOUNCE)) begin
      flag_c = dir;
    end
    pos_adv_c  = pos_q;
    flag_adv_c = flag_c;
    if (mode == MODE_BOUNCE) begin
      if (!flag_c) begin
        if (pos_q == 3'd7) begin
          flag_adv_c = 1'b1;
          pos_adv_c  = 3'd6;
        end else begin
          pos_adv_c = pos_q + 3'd1;
        end
      end else begin
        if (pos_q == 3'd0) begin
          flag_adv_c = 1'b0;
          pos_adv_c  = 3'd1;
        end else begin
          pos_adv_c = pos_q - 3'd1;
        end
      end
    end else if (dir) begin
      pos_adv_c = pos_q - 3'd1;
    end else begin
      pos_adv_c = pos_q + 3'd1;
    end
  end

  // State machine, prescaler and position update; ena low freezes everything
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    pre_d       = pre_q;
    bounce_d    = bounce_q;
    mode_prev_d = mode_prev_q;
    step_d      = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d     = RUN;
            pre_d       = '0;
            pos_d       = dir ? 3'd7 : 3'd0;
            bounce_d    = dir;
            mode_prev_d = mode;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = HOLD;
          end else begin
            mode_prev_d = mode;
            bounce_d    = flag_c;
            if (pre_q >= term_c) begin
              pre_d    = '0;
              pos_d    = pos_adv_c;
              bounce_d = flag_adv_c;
              step_d   = 1'b1;
            end else begin
              pre_d = pre_q + DIV_W'(1);
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state_d = IDLE;
            pos_d   = '0;
            pre_d   = '0;
          end else if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      pre_q       <= '0;
      bounce_q    <= 1'b0;
      step_q      <= 1'b0;
      mode_prev_q <= MODE_DOT;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pre_q       <= pre_d;
      bounce_q    <= bounce_d;
      step_q      <= step_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  // Pattern decode from registered position; mode changes show immediately
  always_comb begin
    led = 8'h00;
    if (state_q != IDLE) begin
      case (mode)
        MODE_BAR:  led = (8'd1 << pos_q) | (8'd1 << (pos_q + 3'd1));
        MODE_FILL: led = 8'hFF >> (3'd7 - pos_q);
        default:   led = 8'd1 << pos_q;
      endcase
    end
  end

  assign step    = step_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_led_spin_sequencer.sv
// Scoreboard bench for led_spin_sequencer: a cycle model pushes expected
// outputs per clock, they are popped and compared after the edge.
module tb_led_spin_sequencer;

  localparam int unsigned BASE_DIV = 4;
  localparam int unsigned DIV_W    = 24;
  localparam logic [7:0] BOUNCE_EXP [15] = '{
    8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02
  };

  logic       clk = 1'b0;
  logic       rst, ena, start, stop, dir;
  logic [2:0] speed;
  logic [1:0] mode;
  logic [7:0] led;
  logic       step, running;

  typedef struct packed {
    logic [7:0] led;
    logic       step;
    logic       running;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model state (0 idle, 1 run, 2 hold)
  int m_state, m_pos, m_pre, m_prev_mode;
  bit m_flag, m_step;

  always #5 clk = ~clk;

  led_spin_sequencer #(.BASE_DIV(BASE_DIV), .DIV_W(DIV_W)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .dir(dir), .speed(speed), .mode(mode),
    .led(led), .step(step), .running(running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  task automatic m_reset();
    m_state = 0; m_pos = 0; m_pre = 0; m_flag = 0; m_step = 0; m_prev_mode = 0;
  endtask

  function automatic logic [7:0] m_led();
    logic [7:0] v = 8'h00;
    if (m_state != 0) begin
      case (mode)
        2'd1: begin v[m_pos] = 1'b1; v[(m_pos + 1) % 8] = 1'b1; end
        2'd2: for (int i = 0; i <= m_pos; i++) v[i] = 1'b1;
        default: v[m_pos] = 1'b1;
      endcase
    end
    return v;
  endfunction

  // model of one rising edge given the inputs currently applied
  task automatic model_edge();
    int t;
    bit f;
    if (rst) begin m_reset(); return; end
    m_step = 0;
    if (!ena) return;
    case (m_state)
      0: if (start && !stop) begin
           m_state = 1; m_pre = 0; m_pos = dir ? 7 : 0; m_flag = dir; m_prev_mode = int'(mode);
         end
      1: if (stop) m_state = 2;
         else begin
           f = m_flag;
           if (mode == 2'd3 && m_prev_mode != 3) f = dir;
           m_prev_mode = int'(mode);
           t = (BASE_DIV << speed) - 1;
           if (m_pre >= t) begin
             m_pre = 0; m_step = 1;
             if (mode == 2'd3) begin
               if (!f) begin
                 if (m_pos == 7) begin f = 1; m_pos = 6; end else m_pos++;
               end else begin
                 if (m_pos == 0) begin f = 0; m_pos = 1; end else m_pos--;
               end
             end else begin
               m_pos = (m_pos + (dir ? 7 : 1)) % 8;
             end
           end else begin
             m_pre++;
           end
           m_flag = f;
         end
      default: if (stop) begin m_state = 0; m_pos = 0; m_pre = 0; end
               else if (start) m_state = 1;
    endcase
  endtask

  // one clock: predict, push, edge, pop and compare; start/stop are one-cycle
  task automatic tick();
    exp_t e;
    model_edge();
    e.led = m_led(); e.step = m_step; e.running = (m_state == 1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("led", led, e.led);
    check("step", step, e.step);
    check("running", running, e.running);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_step(input string tag, input int want);
    int n = 0;
    do begin tick(); n++; end while (step !== 1'b1 && n < 600);
    check(tag, n, want);
  endtask

  task automatic halt_to_idle();
    stop = 1'b1; tick();
    stop = 1'b1; tick();
  endtask

  initial begin
    logic [7:0] frozen;
    m_reset();
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    speed = 3'd0; mode = 2'd0;
    tick(); tick();
    check("rst_led", led, 8'h00);
    check("rst_run", running, 1'b0);
    rst = 1'b0;
    tick();

    // ascending dot, wrap after 0x80
    start = 1'b1; tick();
    check("dot_first", led, 8'h01);
    check("dot_running", running, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      wait_step("dot_period", 4);
      check("dot_led", led, 32'(8'd1 << (k % 8)));
    end
    halt_to_idle();
    check("idle_led", led, 8'h00);

    // descending bar with speed drop mid-period
    mode = 2'd1; dir = 1'b1; speed = 3'd2;
    start = 1'b1; tick();
    check("bar_first", led, 8'h81);
    wait_step("bar_period16", 16);
    check("bar_second", led, 8'hC0);
    for (int k = 0; k < 8; k++) tick();
    speed = 3'd0;
    wait_step("bar_speed_drop", 1);
    wait_step("bar_period4", 4);
    halt_to_idle();

    // bounce
    mode = 2'd3; dir = 1'b0; speed = 3'd0;
    start = 1'b1; tick();
    check("bounce_first", led, 8'h01);
    for (int k = 0; k < 15; k++) begin
      wait_step("bounce_period", 4);
      check("bounce_led", led, 32'(BOUNCE_EXP[k]));
    end
    halt_to_idle();

    // stop at prescaler 2, resume, stop twice, start+stop in idle
    mode = 2'd0; dir = 1'b0;
    start = 1'b1; tick();
    tick(); tick();
    stop = 1'b1; tick();
    check("hold_running", running, 1'b0);
    frozen = led;
    tick(); tick();
    check("hold_led", led, 32'(frozen));
    start = 1'b1; tick();
    wait_step("resume_latency", 2);
    halt_to_idle();
    check("stop_stop_led", led, 8'h00);
    start = 1'b1; stop = 1'b1; tick();
    check("start_stop_idle", running, 1'b0);

    // ena low for 10 cycles mid-run, with ignored pulses
    start = 1'b1; tick();
    tick();
    frozen = led;
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) stop = 1'b1;
      if (k == 6) start = 1'b1;
      tick();
      check("ena_step", step, 1'b0);
      check("ena_led", led, 32'(frozen));
    end
    ena = 1'b1;
    wait_step("ena_resume", 3);

    // live mode change, then bounce entry takes its flag from dir
    wait_step("pre_mode", 4);
    mode = 2'd2; #1;
    check("fill_live", led, 8'h07);
    mode = 2'd3; dir = 1'b1;
    wait_step("enter_bounce", 4);
    check("bounce_desc", led, 8'h02);
    dir = 1'b0;
    wait_step("bounce_a", 4);
    check("bounce_at0", led, 8'h01);
    wait_step("bounce_b", 4);
    check("bounce_turn", led, 8'h02);

    // asynchronous reset right after a step, no clock edge
    rst = 1'b1; #1;
    check("arst_led", led, 8'h00);
    check("arst_step", step, 1'b0);
    check("arst_running", running, 1'b0);
    m_reset();
    tick();
    rst = 1'b0;
    mode = 2'd0; dir = 1'b0;
    start = 1'b1; tick();
    check("post_rst_start", running, 1'b1);

    // randomized stretch against the model
    for (int k = 0; k < 600; k++) begin
      ena   = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 31) == 0) speed = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 23) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_spin_sequencer.md
LED_SPIN_SEQUENCER -- requirements
Module: led_spin_sequencer

Interface
REQ-001 Parameter BASE_DIV, default 4: base step period in clk cycles at speed=0; legal range 1..2^16-1.
REQ-002 Parameter DIV_W, default 24: prescaler counter width; BASE_DIV<<7 SHALL fit in DIV_W bits.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ena  in  1  global enable; low freezes all state.
REQ-006 start  in  1  single-cycle request to run or resume.
REQ-007 stop  in  1  single-cycle request to hold or stop.
REQ-008 dir  in  1  0 = ascending position, 1 = descending.
REQ-009 speed  in  3  step period = BASE_DIV<<speed cycles.
REQ-010 mode  in  2  0 dot, 1 bar, 2 fill, 3 bounce.
REQ-011 led  out  8  LED pattern.
REQ-012 step  out  1  one-cycle pulse on each position advance.
REQ-013 running  out  1  high while in RUN.

Function
REQ-014 Three states: IDLE, RUN, HOLD. running = (state==RUN).
REQ-015 IDLE + start: go to RUN, prescaler=0, pos=0 (dir=0) or 7 (dir=1), bounce flag=dir.
REQ-016 RUN + stop: go to HOLD; pos, prescaler and bounce flag frozen; led unchanged.
REQ-017 HOLD + start: return to RUN, resuming from the frozen prescaler value.
REQ-018 HOLD + stop: go to IDLE, pos=0, prescaler=0.
REQ-019 start and stop high in the same cycle: stop wins; in IDLE, no transition.
REQ-020 start in RUN and stop in IDLE are ignored.
REQ-021 ena low: no state, prescaler or pos change; step=0; start/stop ignored that cycle.
REQ-022 In RUN with ena high, the prescaler increments each cycle.
REQ-023 Terminal count T = (BASE_DIV<<speed)-1, evaluated live each cycle.
REQ-024 When prescaler >= T: prescaler->0, pos advances, and step=1 on the same edge.
REQ-025 The >= compare handles a speed decrease mid-period: the step fires on the next RUN cycle.
REQ-026 Modes 0-2: pos = pos+1 mod 8 (dir=0) or pos-1 mod 8 (dir=1); dir is sampled at each step.
REQ-027 Mode 3 (bounce): ascending at pos 7 -> flag=1, pos 6; descending at pos 0 -> flag=0, pos 1; else move per flag; dir ignored.
REQ-028 led decode, combinational from registered state: IDLE -> 0x00.
REQ-029 mode0 and mode3 -> 1<<pos.
REQ-030 mode1 -> (1<<pos) | (1<<((pos+1) mod 8)).
REQ-031 mode2 -> (2<<pos)-1 (thermometer, bits 0..pos).
REQ-032 Mode change mid-run applies to decode immediately; pos is kept.
REQ-033 On entering mode 3 from another mode, the bounce flag is loaded from dir.
REQ-034 step is registered; it is high only in the cycle following the advancing edge.

Reset
REQ-035 While rst=1 (asynchronous): state=IDLE, pos=0, prescaler=0, bounce flag=0, led=0x00, step=0, running=0.
REQ-036 After rst deasserts, the first start is honoured on the next edge; mid-run reset clears immediately without waiting for clk.

Verification
REQ-037 Reset: assert rst mid-RUN, no clock edge -> led=0x00, step=0, running=0.
REQ-038 Ascending dot: BASE_DIV=4, speed=0, mode0, dir=0, start pulse.
- running=1 and led=0x01 next cycle.
- step every 4 cycles; led 0x02,0x04,...,0x80, then wraps to 0x01.
REQ-039 Descending bar: speed=2, dir=1, mode1, start.
- led=0x81 first.
- step every 16 cycles; next led=0xC0.
- At mid-period, speed->0: step on the next cycle, then every 4.
REQ-040 Bounce, mode3:
- led sequence 0x01,0x02,...,0x80,0x40,...,0x01,0x02.
- Each adjacent pair separated by exactly one step.
REQ-041 Stop/resume: stop at prescaler=2 -> running=0, led frozen.
- start -> next step arrives 2 cycles later.
- stop, stop -> IDLE, led=0x00.
- start+stop together in IDLE -> stays IDLE.
REQ-042 ena low 10 cycles mid-RUN: no step, led and prescaler unchanged; start/stop pulses during that window are ignored.
